// File: rtl/handshake_pkg.sv
// ---------------------------------------------------------------------------
// handshake_pkg
//   Shared definitions for the handshake control-token extractor:
//     OCC_W        width of the occupancy count (tokens currently buffered)
//     CNT_W        width of the running accepted-token statistic
//     occ_state_t  EMPTY / PARTIAL / FULL buffer state encoding
//     classify_occupancy()  maps an occupancy value onto the state encoding
// ---------------------------------------------------------------------------
package handshake_pkg;

  localparam int OCC_W = 8;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_t;

  // A buffer of depth 1 jumps straight from EMPTY to FULL, so the FULL test
  // must take priority over PARTIAL for any non-zero occupancy.
  function automatic occ_state_t classify_occupancy(
    input logic [OCC_W-1:0] occ,
    input logic [OCC_W-1:0] depth
  );
    occ_state_t st;
    if (occ == '0) begin
      st = EMPTY;
    end else if (occ == depth) begin
      st = FULL;
    end else begin
      st = PARTIAL;
    end
    return st;
  endfunction

endpackage

// File: rtl/handshake_token_counter.sv
// ---------------------------------------------------------------------------
// handshake_token_counter
//   Up/down counter of buffered control tokens together with the
//   EMPTY/PARTIAL/FULL state register. Both are updated in one clocked block
//   so the state always agrees with the count.
//
//   Parameters
//     DEPTH   maximum number of buffered tokens (1..255)
//   Ports
//     clk     rising-edge clock
//     rst     asynchronous active-low reset
//     inc     a token was accepted this cycle
//     dec     a token was consumed this cycle
//     count   number of buffered tokens (0..DEPTH)
//     state   EMPTY / PARTIAL / FULL
// ---------------------------------------------------------------------------
module handshake_token_counter
  import handshake_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] count,
  output occ_state_t       state
);

  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  logic             inc_ok;
  logic             dec_ok;
  logic [OCC_W-1:0] count_next;
  occ_state_t       state_next;

  // The qualifiers against FULL/EMPTY keep the count inside 0..DEPTH even if
  // a caller ever presents an unqualified inc/dec. Simultaneous inc and dec
  // cancel out and leave the count unchanged.
  always_comb begin
    inc_ok     = inc && (state != FULL);
    dec_ok     = dec && (state != EMPTY);
    count_next = count;
    if (inc_ok && !dec_ok) begin
      count_next = count + OCC_W'(1);
    end else if (dec_ok && !inc_ok) begin
      count_next = count - OCC_W'(1);
    end
    state_next = classify_occupancy(count_next, DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      state <= EMPTY;
    end else begin
      count <= count_next;
      state <= state_next;
    end
  end

endmodule

// File: rtl/handshake_ctrl_extract.sv
// ---------------------------------------------------------------------------
// handshake_ctrl_extract
//   Converts a data-carrying valid/ready channel into a data-less control
//   token channel. Every accepted input word produces exactly one control
//   token, in order; up to DEPTH tokens can be buffered. The word itself is
//   dropped, optionally after being compared against EXPECTED.
//
//   Optional feature macro: HANDSHAKE_CTRL_EXTRACT_CHECK_EN
//     defined   -> each accepted word is compared with EXPECTED; the first
//                  differing word raises the sticky mismatch flag and is
//                  captured in mismatch_data
//     undefined -> mismatch and mismatch_data are constant 0
//
//   Parameters
//     DATA_WIDTH    width of the input data word
//     DEPTH         maximum buffered control tokens (1..255)
//     EXPECTED      reference value for the optional word checker
//   Ports
//     clk           rising-edge clock
//     rst           asynchronous active-low reset
//     ins           input data word
//     ins_valid     input token offered
//     ins_ready     input token can be accepted (buffer not full)
//     outs_valid    control token offered (buffer not empty)
//     outs_ready    downstream consumes the control token
//     occupancy     number of buffered tokens
//     accepted_cnt  accepted input tokens since reset, wraps at 2^16
//     mismatch      sticky flag: an accepted word differed from EXPECTED
//     mismatch_data first differing word
// ---------------------------------------------------------------------------
module handshake_ctrl_extract
  import handshake_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] EXPECTED   = 32'h5F78E7F2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [OCC_W-1:0]      occupancy,
  output logic [CNT_W-1:0]      accepted_cnt,
  output logic                  mismatch,
  output logic [DATA_WIDTH-1:0] mismatch_data
);

  occ_state_t state;
  logic       accept;
  logic       consume;

  // Both handshake outputs are pure decodes of the state register, so there
  // is no combinational path from ins_valid or outs_ready to either of them.
  assign ins_ready  = (state != FULL);
  assign outs_valid = (state != EMPTY);

  assign accept  = ins_valid && ins_ready;
  assign consume = outs_valid && outs_ready;

  handshake_token_counter #(
    .DEPTH (DEPTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .dec   (consume),
    .count (occupancy),
    .state (state)
  );

  // Running count of accepted tokens; wraps naturally at the register width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      accepted_cnt <= '0;
    end else if (accept) begin
      accepted_cnt <= accepted_cnt + CNT_W'(1);
    end
  end

`ifdef HANDSHAKE_CTRL_EXTRACT_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] EXPECTED_W = DATA_WIDTH'(EXPECTED);

  // Only the first differing word is captured: once mismatch is set the
  // capture register is frozen until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch      <= 1'b0;
      mismatch_data <= '0;
    end else if (accept && !mismatch && (ins != EXPECTED_W)) begin
      mismatch      <= 1'b1;
      mismatch_data <= ins;
    end
  end
`else
  logic unused_ins;

  assign mismatch      = 1'b0;
  assign mismatch_data = '0;

  // The data word is intentionally dropped when the checker is not built.
  assign unused_ins = ^{ins, EXPECTED};
`endif

endmodule

// File: tb/tb_handshake_ctrl_extract.sv
// ---------------------------------------------------------------------------
// tb_handshake_ctrl_extract
//   Directed-vector bench for handshake_ctrl_extract (default parameters).
//   Each vector carries hand-computed register values expected after the
//   clock edge it is applied to; those are queued by the stimulus side and
//   popped and compared by an independent monitor process.
// ---------------------------------------------------------------------------
module tb_handshake_ctrl_extract;

  localparam logic [31:0] EXP_WORD = 32'h5F78E7F2;
`ifdef HANDSHAKE_CTRL_EXTRACT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        outs_valid;
  logic        outs_ready;
  logic [7:0]  occupancy;
  logic [15:0] accepted_cnt;
  logic        mismatch;
  logic [31:0] mismatch_data;

  typedef struct {
    string       name;
    logic [7:0]  occ;
    logic        rdy;
    logic        vld;
    logic [15:0] cnt;
    logic        mm;
    logic [31:0] md;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  handshake_ctrl_extract dut (
    .clk           (clk),
    .rst           (rst),
    .ins           (ins),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .outs_valid    (outs_valid),
    .outs_ready    (outs_ready),
    .occupancy     (occupancy),
    .accepted_cnt  (accepted_cnt),
    .mismatch      (mismatch),
    .mismatch_data (mismatch_data)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input string n, input int occ, input bit rdy,
                              input bit vld, input int cnt, input bit mm,
                              input logic [31:0] md);
    exp_t e;
    e.name = n;
    e.occ  = 8'(occ);
    e.rdy  = rdy;
    e.vld  = vld;
    e.cnt  = 16'(cnt);
    e.mm   = mm;
    e.md   = md;
    return e;
  endfunction

  task automatic checkField(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField({e.name, ".occupancy"},     32'(occupancy),    32'(e.occ));
    checkField({e.name, ".ins_ready"},     32'(ins_ready),    32'(e.rdy));
    checkField({e.name, ".outs_valid"},    32'(outs_valid),   32'(e.vld));
    checkField({e.name, ".accepted_cnt"},  32'(accepted_cnt), 32'(e.cnt));
    checkField({e.name, ".mismatch"},      32'(mismatch),     32'(e.mm));
    checkField({e.name, ".mismatch_data"}, mismatch_data,     e.md);
  endtask

  // Drive one vector at the falling edge and queue what the registers must
  // hold after the following rising edge.
  task automatic applyStimulus(input logic iv, input logic [31:0] data,
                               input logic ordy, input exp_t e);
    @(negedge clk);
    ins_valid  = iv;
    ins        = data;
    outs_ready = ordy;
    exp_q.push_back(e);
  endtask

  task automatic goIdle();
    @(negedge clk);
    ins_valid  = 1'b0;
    outs_ready = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    ins_valid  = 1'b0;
    outs_ready = 1'b0;
    rst        = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: after each rising edge, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int n;
    ins        = '0;
    ins_valid  = 1'b0;
    outs_ready = 1'b0;
    rst        = 1'b1;
    #1 rst     = 1'b0;
    #1;
    checkOutput(mk("reset", 0, 1, 0, 0, 0, 32'h0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Word checker: correct word, then two different wrong words.
    applyStimulus(1'b1, EXP_WORD, 1'b0, mk("chk1", 1, 1, 1, 1, 0, 32'h0));
    applyStimulus(1'b1, 32'h1, 1'b0,
                  mk("chk2", 2, 1, 1, 2, CHECK_EN, CHECK_EN ? 32'h1 : 32'h0));
    applyStimulus(1'b1, 32'h2, 1'b0,
                  mk("chk3", 3, 1, 1, 3, CHECK_EN, CHECK_EN ? 32'h1 : 32'h0));
    goIdle();

    // Asynchronous reset mid-operation with three tokens buffered.
    #2 rst = 1'b0;
    #1;
    checkOutput(mk("rst_mid", 0, 1, 0, 0, 0, 32'h0));
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, EXP_WORD, 1'b0, mk("post_rst", 1, 1, 1, 1, 0, 32'h0));
    goIdle();

    // Fill with downstream stalled: accepts stop at DEPTH.
    doReset();
    for (int i = 1; i <= 6; i++) begin
      n = (i < 4) ? i : 4;
      applyStimulus(1'b1, EXP_WORD, 1'b0,
                    mk($sformatf("fill%0d", i), n, n != 4, 1, n, 0, 32'h0));
    end

    // Drain a full buffer.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, EXP_WORD, 1'b1,
                    mk($sformatf("drain%0d", i), 4 - i, 1, i != 4, 4, 0, 32'h0));
    end

    // Build occupancy 2, then stream with accept and consume together.
    applyStimulus(1'b1, EXP_WORD, 1'b0, mk("pre1", 1, 1, 1, 5, 0, 32'h0));
    applyStimulus(1'b1, EXP_WORD, 1'b0, mk("pre2", 2, 1, 1, 6, 0, 32'h0));
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, EXP_WORD, 1'b1,
                    mk($sformatf("stream%0d", i), 2, 1, 1, 6 + i, 0, 32'h0));
    end

    // Full with both sides active: only the consume happens.
    applyStimulus(1'b1, EXP_WORD, 1'b0, mk("top3", 3, 1, 1, 17, 0, 32'h0));
    applyStimulus(1'b1, EXP_WORD, 1'b0, mk("top4", 4, 0, 1, 18, 0, 32'h0));
    applyStimulus(1'b1, EXP_WORD, 1'b1, mk("full_both", 3, 1, 1, 18, 0, 32'h0));
    applyStimulus(1'b1, EXP_WORD, 1'b1, mk("after_full", 3, 1, 1, 19, 0, 32'h0));
    goIdle();

    // 65537 accepts: first edge from EMPTY, then one accept per edge.
    doReset();
    @(negedge clk);
    ins_valid  = 1'b1;
    ins        = EXP_WORD;
    outs_ready = 1'b1;
    repeat (65536) @(negedge clk);
    exp_q.push_back(mk("wrap", 1, 1, 1, 1, 0, 32'h0));
    goIdle();

    // Bounded wait for the monitor to drain the expectation queue.
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkField("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
